// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder issuer: FSM state encoding and IEEE-754 single field positions.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESULT  = 2'd2,
    ST_RECOVER = 2'd3
  } fp_state_e;

  localparam int FP_WIDTH    = 32;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MAN_MSB  = 22;
  localparam int FP_MAN_LSB  = 0;

  // Subtraction is issued as an add with the second operand's sign inverted.
  function automatic logic [FP_WIDTH-1:0] fp_flip_sign(input logic [FP_WIDTH-1:0] v,
                                                        input logic flip);
    return {v[FP_SIGN_BIT] ^ flip, v[FP_EXP_MSB:FP_EXP_LSB], v[FP_MAN_MSB:FP_MAN_LSB]};
  endfunction

endpackage

// File: rtl/fp_watchdog.sv
// Issue watchdog: down-counter reloaded while en is low; expired marks the TIMEOUT_CYCLES-th
// consecutive enabled cycle. Only instantiated when FP_ISSUE_TIMEOUT_EN is defined.
module fp_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (!en) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/fp_add_issuer.sv
// Issues one IEEE-754 single add/sub at a time to a level-started adder and holds the result
// for a valid/ready consumer. Optional issue watchdog enabled by defining FP_ISSUE_TIMEOUT_EN.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | in_ready high, waiting for an operand pair
//   ST_ISSUE   | str_sig high, operands held, waiting for done_sig
//   ST_RESULT  | out_valid high, result held until out_ready
//   ST_RECOVER | adder rest period, RECOVER_CYCLES cycles with str_sig low
module fp_add_issuer
  import fp_pkg::*;
#(
  parameter int RECOVER_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] in_a,
  input  logic [FP_WIDTH-1:0] in_b,
  input  logic                in_sub,
  output logic                str_sig,
  output logic [FP_WIDTH-1:0] da_in1,
  output logic [FP_WIDTH-1:0] da_in2,
  input  logic [FP_WIDTH-1:0] da_out,
  input  logic                done_sig,
  input  logic                error,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out_data,
  output logic                out_err,
  output logic                out_timeout
);

  localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RCW-1:0] REC_LOAD = (RECOVER_CYCLES > 0) ? RCW'(RECOVER_CYCLES - 1) : '0;

  fp_state_e      state;
  fp_state_e      state_nxt;
  logic [RCW-1:0] rec_cnt;
  logic           timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    str_sig   = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        str_sig = 1'b1;
        if (done_sig || timeout_hit) state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (rec_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands only load on acceptance, so they stay fixed from ISSUE through RECOVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_in1 <= '0;
      da_in2 <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      da_in1 <= in_a;
      da_in2 <= fp_flip_sign(in_b, in_sub);
    end
  end

  // A done pulse in the same cycle as watchdog expiry wins over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (state == ST_ISSUE) begin
      if (done_sig) begin
        out_data <= da_out;
        out_err  <= error;
      end else if (timeout_hit) begin
        out_data <= '0;
        out_err  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_cnt <= '0;
    end else if (state == ST_RESULT) begin
      rec_cnt <= REC_LOAD;
    end else if (state == ST_RECOVER && rec_cnt != '0) begin
      rec_cnt <= rec_cnt - RCW'(1);
    end
  end

`ifdef FP_ISSUE_TIMEOUT_EN
  fp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == ST_ISSUE),
    .expired(timeout_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_timeout <= 1'b0;
    end else if (state == ST_ISSUE) begin
      if (done_sig) begin
        out_timeout <= 1'b0;
      end else if (timeout_hit) begin
        out_timeout <= 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_hit           = 1'b0;
  assign out_timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_issuer.sv
// Scoreboard bench for fp_add_issuer: randomized integer-valued float operands, a behavioural
// adder model, and a monitor that checks every accepted result against the expected queue.
module tb_fp_add_issuer;

  localparam int RECOVER_CYCLES = 4;
  localparam int TIMEOUT_CYCLES = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        str_sig;
  logic [31:0] da_in1;
  logic [31:0] da_in2;
  logic [31:0] da_out;
  logic        done_sig;
  logic        error;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_timeout;

  always #5 clk = ~clk;

  fp_add_issuer #(
    .RECOVER_CYCLES(RECOVER_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .str_sig    (str_sig),
    .da_in1     (da_in1),
    .da_in2     (da_in2),
    .da_out     (da_out),
    .done_sig   (done_sig),
    .error      (error),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_timeout(out_timeout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic        err;
  } plan_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        tmo;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    rdy_mode = 0;
  bit    keep_valid = 1'b0;

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  // Exact for the small integer values used here; zero handled explicitly.
  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'h0) return 0.0;
    d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] i2s(input int i);
    return r2s(real'(i));
  endfunction

  initial begin : ready_driver
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 3) != 0;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Adder model: answers after the planned number of ISSUE cycles (0 = never), and drives
  // junk done/error/data whenever str_sig is low.
  initial begin : adder_model
    plan_t cur;
    bit    busy  = 1'b0;
    bit    track = 1'b0;
    bit    held  = 1'b1;
    bit    seen  = 1'b0;
    int    cnt   = 0;
    int    gap   = 0;
    cur = '{a: 32'h0, b: 32'h0, lat: 1, err: 1'b0};
    done_sig = 1'b0;
    error    = 1'b0;
    da_out   = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy = 1'b0; track = 1'b0; seen = 1'b0; gap = 0;
        done_sig = 1'b0; error = 1'b0;
        continue;
      end
      if (str_sig) begin
        if (!busy) begin
          if (seen) check("str_gap", gap >= RECOVER_CYCLES, gap, RECOVER_CYCLES);
          if (plan_q.size() == 0) begin
            check("plan_available", 1'b0, 0, 1);
            cur = '{a: da_in1, b: da_in2, lat: 1, err: 1'b0};
          end else begin
            cur = plan_q.pop_front();
          end
          check("da_in1", da_in1 === cur.a, da_in1, cur.a);
          check("da_in2", da_in2 === cur.b, da_in2, cur.b);
          busy = 1'b1; track = 1'b1; held = 1'b1; seen = 1'b1; cnt = 0;
        end
        cnt++;
        gap = 0;
        if (cur.lat != 0 && cnt == cur.lat) begin
          done_sig = 1'b1;
          error    = cur.err;
          da_out   = r2s(s2r(da_in1) + s2r(da_in2));
        end else begin
          done_sig = 1'b0;
          error    = 1'($urandom % 2);
          da_out   = $urandom;
        end
      end else begin
        if (busy) begin
          check("issue_cycles", cnt == ((cur.lat == 0) ? TIMEOUT_CYCLES : cur.lat), cnt,
                (cur.lat == 0) ? TIMEOUT_CYCLES : cur.lat);
          busy = 1'b0;
        end
        if (track && in_ready) begin
          check("operands_held", held, held, 1);
          track = 1'b0;
        end
        gap++;
        done_sig = ($urandom % 4) == 0;
        error    = 1'($urandom % 2);
        da_out   = $urandom;
      end
      if (track && (da_in1 !== cur.a || da_in2 !== cur.b)) held = 1'b0;
    end
  end

  initial begin : monitor
    exp_t e;
    bit   done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_prev = 1'b0;
        continue;
      end
      if (done_prev) check("result_latency", out_valid === 1'b1, out_valid, 1);
      done_prev = str_sig && done_sig;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1'b0, out_data, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data === e.data, out_data, e.data);
          check("out_err", out_err === e.err, out_err, e.err);
          check("out_timeout", out_timeout === e.tmo, out_timeout, e.tmo);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] exp_b, input logic [31:0] exp_res, input int lat,
                      input logic err);
    plan_t p;
    exp_t  e;
    int    waited = 0;
    p = '{a: a, b: exp_b, lat: lat, err: err};
    e = '{data: (lat == 0) ? 32'h0 : exp_res, err: (lat == 0) ? 1'b0 : err, tmo: (lat == 0)};
    plan_q.push_back(p);
    exp_q.push_back(e);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 500);
    if (!in_ready) check("accept_wait", 1'b0, in_ready, 1);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic send_rand();
    int   ia, ib, r;
    logic sub;
    ia  = int'($urandom_range(2000)) - 1000;
    ib  = int'($urandom_range(1000, 1));
    if ($urandom % 2) ib = -ib;
    sub = 1'($urandom % 2);
    r   = sub ? ia - ib : ia + ib;
    send(i2s(ia), i2s(ib), sub, i2s(sub ? -ib : ib), i2s(r), int'($urandom_range(12, 1)),
         ($urandom % 4) == 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("drain", 1'b0, exp_q.size(), 0);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 500);
    if (!out_valid) check("out_valid_wait", 1'b0, out_valid, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_time_limit: actual expired required finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int          n;
    bit          ok_v, ok_d, ok_r, ok_s;
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; in_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_str_sig", str_sig === 1'b0, str_sig, 0);
    check("rst_out_valid", out_valid === 1'b0, out_valid, 0);
    check("rst_regs", {da_in1, da_in2, out_data} === 96'h0, da_in1 | da_in2 | out_data, 0);
    check("rst_flags", {out_err, out_timeout} === 2'b00, {out_err, out_timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready === 1'b1, in_ready, 1);

    // Directed add and subtract; subtract also measures handshake-to-in_ready latency.
    rdy_mode = 0;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000, 10, 1'b0);
    drain();
    send(32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000, 5, 1'b0);
    wait_out_valid();
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!in_ready && n < 100);
    check("recover_latency", n == 1 + RECOVER_CYCLES, n, 1 + RECOVER_CYCLES);
    drain();

    // Backpressure: result must sit untouched while out_ready stays low.
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send(i2s(7), i2s(5), 1'b1, i2s(-5), i2s(2), 3, 1'b1);
    wait_out_valid();
    held = out_data;
    ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1; ok_s = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1) ok_v = 1'b0;
      if (out_data !== held) ok_d = 1'b0;
      if (in_ready !== 1'b0) ok_r = 1'b0;
      if (str_sig !== 1'b0) ok_s = 1'b0;
    end
    check("bp_out_valid", ok_v, ok_v, 1);
    check("bp_out_data", ok_d, ok_d, 1);
    check("bp_in_ready", ok_r, ok_r, 1);
    check("bp_str_sig", ok_s, ok_s, 1);
    rdy_mode = 0;
    drain();

    // Reset in the third ISSUE cycle of an operation that would never complete.
    send(i2s(1), i2s(1), 1'b0, i2s(1), i2s(2), 0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_str_sig", str_sig === 1'b0, str_sig, 0);
    check("midrst_out_valid", out_valid === 1'b0, out_valid, 0);
    check("midrst_regs", {da_in1, da_in2, out_data} === 96'h0, da_in1 | da_in2 | out_data, 0);
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", in_ready === 1'b1, in_ready, 1);
    send(i2s(10), i2s(4), 1'b1, i2s(-4), i2s(6), 4, 1'b0);
    drain();

`ifdef FP_ISSUE_TIMEOUT_EN
    send(i2s(3), i2s(3), 1'b0, i2s(3), 32'h0, 0, 1'b0);
    drain();
`endif

    // Back-to-back with in_valid held high and random downstream readiness.
    rdy_mode = 1;
    keep_valid = 1'b1;
    repeat (8) send_rand();
    keep_valid = 1'b0;
    in_valid = 1'b0;
    drain();

    repeat (12) begin
      send_rand();
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check("plan_consumed", plan_q.size() == 0, plan_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_add_issuer.md
FP_ADD_ISSUER -- requirements
Module: fp_add_issuer

Interface
REQ-001 SHALL have parameter RECOVER_CYCLES, default 4: minimum idle cycles with str_sig low between adder operations.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for done_sig.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  in  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  out  1  issuer can accept an operand pair.
REQ-007 SHALL have ports in_a, in_b  in  32  IEEE-754 single operands.
REQ-008 SHALL have port in_sub  in  1  compute in_a - in_b.
REQ-009 SHALL have port str_sig  out  1  start level to the adder.
REQ-010 SHALL have ports da_in1, da_in2  out  32  operands to the adder.
REQ-011 SHALL have port da_out  in  32  adder result.
REQ-012 SHALL have ports done_sig, error  in  1  adder completion pulse and error flag.
REQ-013 SHALL have port out_valid  out  1  result available downstream.
REQ-014 SHALL have port out_ready  in  1  downstream accepts result.
REQ-015 SHALL have port out_data  out  32  captured result.
REQ-016 SHALL have ports out_err, out_timeout  out  1  adder error and watchdog expiry for the current result.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> RESULT -> RECOVER -> IDLE.
REQ-018 SHALL drive in_ready = 1 only in IDLE.
REQ-019 SHALL, on in_valid && in_ready, register da_in1 = in_a and da_in2 = {in_b[31]^in_sub, in_b[30:0]}, then enter ISSUE next cycle.
REQ-020 SHALL hold str_sig high for every ISSUE cycle and low in all other states.
REQ-021 SHALL hold da_in1/da_in2 constant from ISSUE entry until RECOVER exit.
REQ-022 SHALL, on the first ISSUE cycle with done_sig = 1, capture out_data = da_out and out_err = error, and enter RESULT next cycle with str_sig low.
REQ-023 SHALL hold out_valid = 1 in RESULT with out_data/out_err/out_timeout stable until out_ready = 1.
REQ-024 SHALL enter RECOVER on out_valid && out_ready, count RECOVER_CYCLES cycles, then enter IDLE.
REQ-025 SHALL ignore done_sig outside ISSUE.
REQ-026 SHALL give minimum issue-to-result latency of 1 cycle after done_sig, and 1 + RECOVER_CYCLES cycles from result handshake to in_ready.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-ISSUE, force IDLE with str_sig, out_valid, out_err, out_timeout = 0 and da_in1, da_in2, out_data = 32'h0.
REQ-028 SHALL drive in_ready = 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with FP_ISSUE_TIMEOUT_EN defined, count ISSUE cycles and, at TIMEOUT_CYCLES without done_sig, enter RESULT with out_data = 32'h0, out_err = 0 and out_timeout = 1.
REQ-030 SHALL, without FP_ISSUE_TIMEOUT_EN, wait in ISSUE indefinitely and tie out_timeout to 0.

Structure
REQ-031 SHALL take the state enum and the IEEE-754 field constants (sign bit 31, exponent 30:23, mantissa 22:0) from shared package fp_pkg.
REQ-032 SHALL place the cycle counter in sub-module fp_watchdog, instantiated only under FP_ISSUE_TIMEOUT_EN; the RECOVER count SHALL use a local counter.

Verification
REQ-033 SHALL cover add: a = 32'h3F800000, b = 32'h40000000, in_sub = 0, adder model returns done after 10 cycles -> da_in2 = 32'h40000000, out_data = 32'h40400000, out_err = 0.
REQ-034 SHALL cover subtract: a = 32'h40400000, b = 32'h3F800000, in_sub = 1 -> da_in2 = 32'hBF800000, out_data = 32'h40000000.
REQ-035 SHALL cover backpressure: out_ready held low 20 cycles -> out_valid and out_data stable, in_ready = 0, str_sig = 0 throughout.
REQ-036 SHALL cover timeout with FP_ISSUE_TIMEOUT_EN: model never pulses done -> after 64 ISSUE cycles, out_valid = 1, out_timeout = 1, out_data = 0.
REQ-037 SHALL cover reset mid-ISSUE: rst_n low at ISSUE cycle 3 -> str_sig = 0 immediately, and the next operation completes normally.
REQ-038 SHALL cover back-to-back requests with in_valid always high -> str_sig low at least 4 cycles between operations and results in order.
